// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
// The TX_PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam int   UART_DATA_BITS   = 8;
   localparam logic UART_IDLE_LEVEL  = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;
   localparam logic UART_STOP_LEVEL  = 1'b1;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
`ifdef UART_TX_PARITY_EN
      TX_PARITY,
`endif
      TX_STOP
   } tx_state_e;

endpackage

// File: rtl/tx_byte_fifo.sv
// Synchronous byte FIFO with registered full flag.
// Pushes while full and pops while empty are ignored; simultaneous
// push and pop leave the count unchanged.
module tx_byte_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic             push_ok, pop_ok;

   assign push_ok = push_i & ~full_q;
   assign pop_ok  = pop_i & ~empty_o;
   assign empty_o = (count_q == '0);
   assign full_o  = full_q;
   assign dout_o  = mem_q[rd_ptr_q];

   // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      full_d = (count_d == FULL_CNT);
   end

   // Pointer, count and full-flag registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
      end
   end

   // Storage array; contents need no reset because occupancy gates every read.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 framer, LSB first.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
// sender_sending is the FIFO-full backpressure to the producing core.
//
// state    | meaning
// ---------+-----------------------------------------------------
// IDLE     | line high, waiting for a byte in the FIFO
// START    | start bit (low) for one bit period
// DATA     | eight data bits, LSB first, one bit period each
// PARITY   | even-parity bit (only with UART_TX_PARITY_EN)
// STOP     | stop bit (high); pops straight into START if data waits
module uart_tx_fifo #(
   parameter int CLK_PER_HALF_BIT = 520,
   parameter int FIFO_DEPTH       = 16
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] w_data,
   input  logic       sender_ready,
   output logic       sender_sending,
   output logic       uart_tx
);

   import uart_pkg::*;

   localparam int BIT_CLKS = 2 * CLK_PER_HALF_BIT;
   localparam int BAUD_W   = $clog2(BIT_CLKS);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CLKS - 1);
   localparam logic [2:0]        LAST_BIT  = 3'(UART_DATA_BITS - 1);

   tx_state_e                 state_q, state_d;
   logic [BAUD_W-1:0]         baud_q, baud_d;
   logic [2:0]                bit_idx_q, bit_idx_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic                      tx_q, tx_d;
   logic                      baud_tc;
   logic                      pop;
   logic [UART_DATA_BITS-1:0] fifo_dout;
   logic                      fifo_full;
   logic                      fifo_empty;
`ifdef UART_TX_PARITY_EN
   logic                      parity_q, parity_d;
`endif

   tx_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (UART_DATA_BITS)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .push_i  (sender_ready),
      .din_i   (w_data),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign baud_tc        = (baud_q == BAUD_LAST);
   assign sender_sending = fifo_full;
   assign uart_tx        = tx_q;

   // State register together with the baud counter, bit index, shift register and line.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= TX_IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

   // Next-state logic: transitions happen on the last clock of a bit period.
   always_comb begin
      state_d   = state_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         TX_IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
               parity_d = ^fifo_dout;
`endif
               state_d = TX_START;
            end
         end
         TX_START: begin
            if (baud_tc) begin
               state_d   = TX_DATA;
               bit_idx_d = '0;
            end
         end
         TX_DATA: begin
            if (baud_tc) begin
               shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  state_d = TX_PARITY;
`else
                  state_d = TX_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         TX_PARITY: begin
            if (baud_tc) state_d = TX_STOP;
         end
`endif
         TX_STOP: begin
            if (baud_tc) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
                  parity_d = ^fifo_dout;
`endif
                  state_d = TX_START;
               end else begin
                  state_d = TX_IDLE;
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase
      // Every state entry and every bit boundary restarts the bit timer.
      if (state_d != state_q || state_q == TX_IDLE || baud_tc) baud_d = '0;
      else                                                      baud_d = baud_q + BAUD_W'(1);
   end

   // Output logic: line level is taken from the upcoming state so it toggles on bit boundaries.
   always_comb begin
      tx_d = UART_IDLE_LEVEL;
      case (state_d)
         TX_IDLE:   tx_d = UART_IDLE_LEVEL;
         TX_START:  tx_d = UART_START_LEVEL;
         TX_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         TX_PARITY: tx_d = parity_d;
`endif
         TX_STOP:   tx_d = UART_STOP_LEVEL;
         default:   tx_d = UART_IDLE_LEVEL;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with 8-clock bits and a 4-entry FIFO.
module tb_uart_tx_fifo;

   localparam int CPHB    = 4;
   localparam int DEPTH   = 4;
   localparam int BIT_CYC = 2 * CPHB;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CYC = BIT_CYC * FRAME_BITS;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic [7:0] w_data = 8'h00;
   logic       sender_ready = 1'b0;
   logic       sender_sending;
   logic       uart_tx;

   uart_tx_fifo #(
      .CLK_PER_HALF_BIT (CPHB),
      .FIFO_DEPTH       (DEPTH)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
      .w_data         (w_data),
      .sender_ready   (sender_ready),
      .sender_sending (sender_sending),
      .uart_tx        (uart_tx)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard of bytes expected on the line, in order.
   logic [7:0] sb[$];
   int         n_exp_frames = 0;
   int         rx_frames = 0;
   int         rx_starts[$];

   // Line receiver: samples the centre of each bit, compares against the scoreboard.
   bit         rx_busy = 1'b0;
   int         rx_cnt = 0;
   int         rx_k = 0;
   logic [7:0] rx_byte = 8'h00;
   logic       rx_par = 1'b0;
   logic [7:0] rx_exp = 8'h00;

   always @(negedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_busy = 1'b0;
      end else if (!rx_busy) begin
         if (uart_tx == 1'b0) begin
            rx_busy = 1'b1;
            rx_cnt  = 0;
            rx_starts.push_back(cyc);
         end
      end else begin
         rx_cnt++;
         if (rx_cnt % BIT_CYC == CPHB) begin
            rx_k = rx_cnt / BIT_CYC;
            if (rx_k == 0) begin
               check("rx_start_bit", int'(uart_tx), 0);
            end else if (rx_k <= 8) begin
               rx_byte[rx_k-1] = uart_tx;
            end else if (rx_k < FRAME_BITS - 1) begin
               rx_par = uart_tx;
            end else begin
               check("rx_stop_bit", int'(uart_tx), 1);
               rx_busy = 1'b0;
               rx_frames++;
               check("rx_frame_expected", int'(sb.size() > 0), 1);
               if (sb.size() > 0) begin
                  rx_exp = sb.pop_front();
                  check("rx_byte", int'(rx_byte), int'(rx_exp));
`ifdef UART_TX_PARITY_EN
                  check("rx_parity", int'(rx_par), int'(^rx_exp));
`endif
               end
            end
         end
      end
   end

   function automatic logic frame_bit(input logic [7:0] d, input logic p, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
      if (k == FRAME_BITS - 1) return 1'b1;
      return p;
   endfunction

   task automatic wait_drain(input string name, input int limit);
      int n = 0;
      while ((sb.size() != 0 || rx_busy) && n < limit) begin
         @(negedge clk);
         n++;
      end
      check({"drain_", name}, sb.size(), 0);
      repeat (CPHB + 2) @(negedge clk);
   endtask

   typedef struct {
      logic [7:0] data;
      logic       par;
   } vec_t;

   vec_t vecs[9];
   logic exp_full[6];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int bad;
      int m;
      int s;
      int n;
      int frames_before;
      logic e;

      vecs[0] = '{8'hAA, 1'b0};
      vecs[1] = '{8'h55, 1'b0};
      vecs[2] = '{8'h00, 1'b0};
      vecs[3] = '{8'hFF, 1'b0};
      vecs[4] = '{8'h01, 1'b1};
      vecs[5] = '{8'h80, 1'b1};
      vecs[6] = '{8'h5A, 1'b0};
      vecs[7] = '{8'hC3, 1'b0};
      vecs[8] = '{8'h07, 1'b1};
      exp_full = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

      // Reset state and quiet idle.
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_uart_tx", int'(uart_tx), 1);
      check("rst_sending", int'(sender_sending), 0);
      rstn = 1'b1;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (uart_tx !== 1'b1 || sender_sending !== 1'b0) bad++;
      end
      check("idle_50_bad_cycles", bad, 0);

      // Single frames: exact cycle-by-cycle line waveform.
      for (int v = 0; v < 9; v++) begin
         sb.push_back(vecs[v].data);
         n_exp_frames++;
         sender_ready = 1'b1;
         w_data       = vecs[v].data;
         @(negedge clk);
         sender_ready = 1'b0;
         bad = 0;
         for (int i = 0; i < FRAME_CYC + 4; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 0 || i > FRAME_CYC) e = 1'b1;
            else e = frame_bit(vecs[v].data, vecs[v].par, (i - 1) / BIT_CYC);
            if (uart_tx !== e || sender_sending !== 1'b0) bad++;
         end
         check($sformatf("frame_wave_%02h", vecs[v].data), bad, 0);
      end

      // Back-to-back frames with no idle gap.
      rx_starts.delete();
      m = cyc;
      for (int i = 1; i <= 3; i++) begin
         sb.push_back(8'(i));
         n_exp_frames++;
         sender_ready = 1'b1;
         w_data       = 8'(i);
         @(negedge clk);
      end
      sender_ready = 1'b0;
      wait_drain("b2b", 4 * FRAME_CYC);
      check("b2b_frames", rx_starts.size(), 3);
      check("b2b_latency", rx_starts[0] - m, 2);
      check("b2b_gap1", rx_starts[1] - rx_starts[0], FRAME_CYC);
      check("b2b_gap2", rx_starts[2] - rx_starts[1], FRAME_CYC);

      // Fill to full, drop a strobe while full, then refill after the next pop.
      m = cyc;
      for (int i = 0; i < 6; i++) begin
         if (i < 5) begin
            sb.push_back(8'h10 + 8'(i));
            n_exp_frames++;
         end
         sender_ready = 1'b1;
         w_data       = 8'h10 + 8'(i);
         @(negedge clk);
         check($sformatf("fill_sending_%0d", i), int'(sender_sending), int'(exp_full[i]));
         if (i == 1) check("fill_first_pop", int'(uart_tx), 0);
      end
      sender_ready = 1'b0;
      s = m + 2;
      n = 0;
      while (sender_sending && n < 2 * FRAME_CYC) begin
         @(negedge clk);
         n++;
      end
      check("full_fall_cycle", cyc - s, FRAME_CYC);
      check("full_fall_line_start", int'(uart_tx), 0);
      sb.push_back(8'h77);
      n_exp_frames++;
      sender_ready = 1'b1;
      w_data       = 8'h77;
      @(negedge clk);
      sender_ready = 1'b0;
      check("refill_sending", int'(sender_sending), 1);
      wait_drain("fill", 7 * FRAME_CYC);

      // Reset in the middle of a data bit with bytes still queued.
      frames_before = rx_frames;
      m = cyc;
      sender_ready = 1'b1;
      w_data = 8'h5A;
      @(negedge clk);
      w_data = 8'h11;
      @(negedge clk);
      w_data = 8'h22;
      @(negedge clk);
      sender_ready = 1'b0;
      s = m + 2;
      n = 0;
      while (cyc < s + 27 && n < FRAME_CYC) begin
         @(negedge clk);
         n++;
      end
      check("pre_reset_line_low", int'(uart_tx), 0);
      rstn = 1'b0;
      #1;
      check("mid_reset_line", int'(uart_tx), 1);
      check("mid_reset_sending", int'(sender_sending), 0);
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      bad = 0;
      repeat (4 * FRAME_CYC) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) bad++;
      end
      check("post_reset_idle_bad_cycles", bad, 0);
      check("post_reset_no_frames", rx_frames - frames_before, 0);

      check("sb_empty_end", sb.size(), 0);
      check("total_frames", rx_frames, n_exp_frames);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
